// File: rtl/spi_shift_bank.sv
// -----------------------------------------------------------------------------
// spi_shift_bank
//   Addressed SPI-slave shift engine. A frame is ADDR_W address bits (MSB
//   first) followed by N data bits. While the data phase shifts the new value
//   in from i_si, the addressed register's readback value shifts out on o_so.
//   At frame end the new value is written into one of NREG output registers
//   and a one-cycle write strobe is raised for that register.
//
//   Optional feature macro: SPI_LSB_FIRST_EN
//     defined   -> data phase is LSB first (address phase stays MSB first)
//     undefined -> data phase is MSB first (default)
//
// Ports
//   i_clk           system clock, all logic on posedge
//   i_reset_n       synchronous active-low reset
//   i_start         session start (chip-select assert), restarts the frame
//   i_shift_en      one bit shifts on this clock edge when high
//   i_si            serial data in
//   o_so            serial data out (decoded from registers)
//   i_write_enable  frame-end write permitted when high
//   i_rd_data       readback values, reg k at [k*N +: N]
//   o_q             written register values, reg k at [k*N +: N]
//   o_wr_strobe     one-cycle pulse, bit k = reg k written
//   o_busy          high while in ADDR or DATA
//   o_done          high in DONE
//   o_addr_err      frame address >= NREG (sticky until start/reset)
// -----------------------------------------------------------------------------
module spi_shift_bank #(
    parameter int             N      = 8,
    parameter int             NREG   = 4,
    parameter int             ADDR_W = 2,
    parameter logic [N-1:0]   INIT   = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_shift_en,
    input  logic              i_si,
    output logic              o_so,
    input  logic              i_write_enable,
    input  logic [NREG*N-1:0] i_rd_data,
    output logic [NREG*N-1:0] o_q,
    output logic [NREG-1:0]   o_wr_strobe,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_addr_err
);

    // state  | meaning
    // S_IDLE | waiting for the first start after reset
    // S_ADDR | shifting in address bits
    // S_DATA | shifting readback out / new value in
    // S_DONE | frame complete, shifts ignored until next start
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // One counter serves both phases, so it must cover the longer of them.
    localparam int CNT_MAX = (N > ADDR_W) ? N : ADDR_W;
    localparam int CW      = $clog2(CNT_MAX);

    state_t              r_state;
    logic [CW-1:0]       r_ctr;
    logic [ADDR_W-1:0]   r_addr;
    logic [N-1:0]        r_sr;
    logic [NREG*N-1:0]   r_q;
    logic [NREG-1:0]     r_wr_strobe;
    logic                r_busy;
    logic                r_done;
    logic                r_addr_err;

    logic [ADDR_W-1:0]   w_addr_next;
    logic [N-1:0]        w_sr_next;
    logic [N-1:0]        w_rd_sel;
    logic                w_addr_hit;
    logic                w_so_bit;

    always_comb begin
        w_addr_next = (r_addr << 1) | ADDR_W'(i_si);
`ifdef SPI_LSB_FIRST_EN
        w_sr_next   = (r_sr >> 1) | (N'(i_si) << (N - 1));
        w_so_bit    = r_sr[0];
`else
        w_sr_next   = (r_sr << 1) | N'(i_si);
        w_so_bit    = r_sr[N-1];
`endif
        // Readback select on the completed address; unmapped addresses read 0.
        w_rd_sel   = '0;
        w_addr_hit = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (w_addr_next == ADDR_W'(k)) begin
                w_rd_sel   = i_rd_data[k*N +: N];
                w_addr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_addr      <= '0;
            r_sr        <= '0;
            r_q         <= {NREG{INIT}};
            r_wr_strobe <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_wr_strobe <= '0;
            if (i_start) begin
                // Any partial frame is discarded; q is left alone.
                r_state    <= S_ADDR;
                r_ctr      <= '0;
                r_addr     <= '0;
                r_sr       <= '0;
                r_addr_err <= 1'b0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else if (i_shift_en) begin
                case (r_state)
                    S_ADDR: begin
                        r_addr <= w_addr_next;
                        if (r_ctr == CW'(ADDR_W - 1)) begin
                            r_sr       <= w_rd_sel;
                            r_addr_err <= ~w_addr_hit;
                            r_ctr      <= '0;
                            r_state    <= S_DATA;
                        end else begin
                            r_ctr <= r_ctr + CW'(1);
                        end
                    end
                    S_DATA: begin
                        r_sr <= w_sr_next;
                        if (r_ctr == CW'(N - 1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            // write_enable only matters on this final edge
                            if (i_write_enable && !r_addr_err) begin
                                for (int k = 0; k < NREG; k++) begin
                                    if (r_addr == ADDR_W'(k)) begin
                                        r_q[k*N +: N]  <= w_sr_next;
                                        r_wr_strobe[k] <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            r_ctr <= r_ctr + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_so        = (r_state == S_DATA || r_state == S_DONE) ? w_so_bit : 1'b0;
    assign o_q         = r_q;
    assign o_wr_strobe = r_wr_strobe;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_addr_err  = r_addr_err;

endmodule
